// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: counts oversample edges and bits through start/data/parity/stop,
// and drives the sampler, deserializer and checker enables plus the frame-valid strobe.
module uart_rx_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int PRESC_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_check_en,
  output logic               stp_chk_en,
  output logic               data_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_SIZE);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         bit_q, bit_d;
  logic               par_en_q, par_en_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;
  logic [PRESC_W-1:0] chk_q, chk_d;
  logic               bit_end, err_capture;
  logic               samp_q, strt_chk_q, deser_q, par_chk_q, stp_chk_q, valid_q;

  // The sampler's majority vote settles two edges past mid-bit.
  assign chk_q       = (presc_q >> 1) + PRESC_W'(2);
  assign chk_d       = (presc_d >> 1) + PRESC_W'(2);
  assign bit_end     = (edge_q == presc_q - PRESC_W'(1));
  assign err_capture = (edge_q == chk_q + PRESC_W'(1));

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no path through the case infers a latch.
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    presc_d  = presc_q;
    par_en_d = par_en_q;
    perr_d   = perr_q;
    serr_d   = serr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        edge_d = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        serr_d = 1'b0;
        if (!RX_IN) begin
          state_d  = S_START;
          presc_d  = prescale;
          par_en_d = PAR_EN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        edge_d = bit_end ? '0 : edge_q + PRESC_W'(1);
        bit_d  = bit_end ? bit_q + 4'd1 : bit_q;
        case (state_q)
          S_START: begin
            if (bit_end) begin
              if (strt_glitch) begin
                state_d = S_IDLE;
                bit_d   = '0;
              end else begin
                state_d = S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bit_end && bit_q == LAST_DATA_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            if (err_capture) perr_d = perr_q | par_err;
            if (bit_end) state_d = S_STOP;
          end
          S_STOP: begin
            if (err_capture) serr_d = serr_q | stp_err;
            if (bit_end) state_d = S_DONE;
          end
          default: ;
        endcase
      end
    endcase
  end

  // Enables are registered from next-state values so each lands in the cycle its condition names.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      samp_q     <= 1'b0;
      strt_chk_q <= 1'b0;
      deser_q    <= 1'b0;
      par_chk_q  <= 1'b0;
      stp_chk_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      samp_q     <= (state_d != S_IDLE);
      strt_chk_q <= (state_d == S_START) && (edge_d == chk_d);
      deser_q    <= (state_d == S_DATA) && (edge_d == chk_d);
      par_chk_q  <= ((state_d == S_PARITY) || (state_d == S_STOP)) && par_en_d;
      stp_chk_q  <= (state_d == S_STOP) && (edge_d == chk_d);
      valid_q    <= (state_d == S_DONE) && !(perr_d || serr_d);
    end
  end

  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;
  assign dat_samp_en  = samp_q;
  assign strt_chk_en  = strt_chk_q;
  assign deser_en     = deser_q;
  assign par_check_en = par_chk_q;
  assign stp_chk_en   = stp_chk_q;
  assign data_valid   = valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed and randomized frames compared cycle by cycle
// against a timeline model derived from frame arithmetic (bit = i / prescale, edge = i % prescale).
module tb_uart_rx_ctrl;
  localparam int DATA_SIZE = 8;
  localparam int PRESC_W   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] prescale;
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               dat_samp_en, strt_chk_en, deser_en, par_check_en, stp_chk_en, data_valid;

  typedef struct packed {
    logic [PRESC_W-1:0] edge_v;
    logic [3:0]         bit_v;
    logic               samp;
    logic               strt;
    logic               deser;
    logic               pce;
    logic               stp;
    logic               dv;
  } outs_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_times[$];
  int deser_cnt = 0;
  int pce_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_SIZE(DATA_SIZE), .PRESC_W(PRESC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_check_en(par_check_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_check_en, stp_chk_en, data_valid};
    return o;
  endfunction

  // Expected outputs for cycle i counted from the first cycle after the start edge was seen.
  function automatic outs_t model(input int i, input int p, input bit pe, input bit perr, input bit serr);
    outs_t m;
    int nb, chk, b, e;
    m   = '0;
    nb  = 1 + DATA_SIZE + int'(pe) + 1;
    chk = p / 2 + 2;
    b   = i / p;
    e   = i % p;
    m.samp = 1'b1;
    if (i == nb * p) begin
      m.dv = !(pe && perr) && !serr;
      return m;
    end
    m.edge_v = PRESC_W'(e);
    m.bit_v  = 4'(b);
    m.strt   = (b == 0) && (e == chk);
    m.deser  = (b >= 1) && (b <= DATA_SIZE) && (e == chk);
    m.pce    = pe && (b > DATA_SIZE);
    m.stp    = (b == nb - 1) && (e == chk);
    return m;
  endfunction

  task automatic idle_cycles(input int n);
    outs_t o;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      o = observed();
      o.bit_v = '0;
      check("idle", 32'(o), 32'(0));
      RX_IN = 1'b1;
      strt_glitch = 1'b0;
      par_err = 1'b0;
      stp_err = 1'b0;
    end
  endtask

  // Drives one frame from the launch cycle (line low while idle/done) and checks every cycle.
  task automatic run_frame(input int p, input bit pe, input logic [7:0] data, input bit glitch,
                           input bit perr, input bit serr, input bit next_start, input bit noise,
                           input int stop_at);
    int nb, last, chk, b, e;
    logic [11:0] line;
    outs_t obs, exp;
    nb   = 1 + DATA_SIZE + int'(pe) + 1;
    last = glitch ? p - 1 : nb * p;
    chk  = p / 2 + 2;
    line = {2'b11, 1'b1, pe ? ^data : 1'b1, data, 1'b0};
    line[10] = 1'b1;
    RX_IN    = 1'b0;
    prescale = PRESC_W'(p);
    PAR_EN   = pe;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      cyc++;
      obs = observed();
      exp = model(i, p, pe, perr, serr);
      if (i == nb * p) obs.bit_v = '0;
      check($sformatf("frame p=%0d pe=%0d i=%0d", p, pe, i), 32'(obs), 32'(exp));
      if (obs.dv) dv_times.push_back(cyc);
      deser_cnt += int'(obs.deser);
      pce_cnt   += int'(obs.pce);
      b = i / p;
      e = i % p;
      prescale = PRESC_W'(8 << $urandom_range(0, 2));
      PAR_EN   = 1'($urandom);
      RX_IN    = (i == last) ? !next_start : line[b];
      strt_glitch = (b == 0 && e > chk) ? glitch : (noise ? 1'($urandom) : 1'b0);
      par_err     = (pe && b == DATA_SIZE + 1 && e == chk + 1) ? perr : (noise ? 1'($urandom) : 1'b0);
      stp_err     = (b == nb - 1 && e == chk + 1) ? serr : (noise ? 1'($urandom) : 1'b0);
      if (i == stop_at) return;
    end
  endtask

  initial begin
    int launch;
    int p;
    bit pe, gl, pr, sr, nx;
    logic [7:0] d;

    rst = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    prescale = PRESC_W'(8);
    strt_glitch = 1'b0;
    par_err = 1'b0;
    stp_err = 1'b0;
    #2 rst = 1'b0;
    #2 check("reset state", 32'(observed()), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(3);

    // prescale 8 with parity, clean frame 0xA5
    dv_times.delete();
    deser_cnt = 0;
    launch = cyc;
    run_frame(8, 1, 8'hA5, 0, 0, 0, 0, 0, -1);
    check("p8 deser pulses", 32'(deser_cnt), 32'(8));
    check("p8 dv count", 32'(dv_times.size()), 32'(1));
    if (dv_times.size() == 1) check("p8 dv latency", 32'(dv_times[0] - launch - 1), 32'(88));
    idle_cycles(2);

    // prescale 16 no parity, back-to-back frames
    dv_times.delete();
    run_frame(16, 0, 8'h3C, 0, 0, 0, 1, 0, -1);
    run_frame(16, 0, 8'hC3, 0, 0, 0, 0, 0, -1);
    check("b2b dv count", 32'(dv_times.size()), 32'(2));
    if (dv_times.size() == 2) check("b2b dv spacing", 32'(dv_times[1] - dv_times[0]), 32'(161));
    idle_cycles(1);

    // start glitch drops the frame; a clean frame 4 cycles later is received
    dv_times.delete();
    deser_cnt = 0;
    run_frame(8, 0, 8'h5A, 1, 0, 0, 0, 0, -1);
    idle_cycles(4);
    check("glitch deser pulses", 32'(deser_cnt), 32'(0));
    check("glitch dv count", 32'(dv_times.size()), 32'(0));
    run_frame(8, 0, 8'h96, 0, 0, 0, 0, 0, -1);
    check("post-glitch dv count", 32'(dv_times.size()), 32'(1));
    idle_cycles(2);

    // parity error suppresses data_valid, next clean frame recovers
    dv_times.delete();
    run_frame(8, 1, 8'h71, 0, 1, 0, 0, 0, -1);
    check("perr dv count", 32'(dv_times.size()), 32'(0));
    idle_cycles(2);
    run_frame(8, 1, 8'h0F, 0, 0, 0, 0, 0, -1);
    check("post-perr dv count", 32'(dv_times.size()), 32'(1));
    idle_cycles(2);

    // prescale 32, stop error, parity enable window length
    dv_times.delete();
    pce_cnt = 0;
    run_frame(32, 1, 8'hE4, 0, 0, 1, 0, 0, -1);
    check("serr dv count", 32'(dv_times.size()), 32'(0));
    check("par_check_en cycles", 32'(pce_cnt), 32'(64));
    idle_cycles(2);

    // randomized frames with noise on the checker inputs outside their valid windows
    for (int n = 0; n < 14; n++) begin
      p  = 8 << $urandom_range(0, 2);
      pe = 1'($urandom);
      d  = 8'($urandom);
      gl = ($urandom_range(0, 5) == 0);
      pr = ($urandom_range(0, 3) == 0);
      sr = ($urandom_range(0, 3) == 0);
      nx = 1'($urandom);
      dv_times.delete();
      run_frame(p, pe, d, gl, pr, sr, nx, 1, -1);
      check($sformatf("rand%0d dv count", n), 32'(dv_times.size()),
            32'((!gl && !(pe && pr) && !sr) ? 1 : 0));
      if (!nx) idle_cycles(1 + $urandom_range(0, 2));
    end
    idle_cycles(1);

    // reset asserted during data bit 4
    dv_times.delete();
    run_frame(8, 0, 8'hFF, 0, 0, 0, 0, 0, 4 * 8 + 3);
    rst = 1'b0;
    #1 check("async reset mid-frame", 32'(observed()), 32'(0));
    @(negedge clk);
    check("held in reset", 32'(observed()), 32'(0));
    RX_IN = 1'b1;
    rst = 1'b1;
    idle_cycles(6);
    check("reset frame dv count", 32'(dv_times.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame-sequencing controller for the UART receiver. It tracks the oversampling edge count and bit count across start, data, optional parity and stop bits. It issues one-cycle strobes and level enables to the sampler, deserializer, start check, parity check and stop check, and raises data_valid for error-free frames. The controller owns all receive timing; the checkers and the deserializer are slaves to its enables.

Parameters:
DATA_SIZE, 8, data bits per frame (LSB first)
PRESC_W, 6, width of prescale and edge_cnt

Ports:
clk  input  1  receiver clock (oversampling clock)
rst  input  1  reset, asynchronous, active-low
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries parity bit
prescale  input  PRESC_W  oversampling ratio; legal values 8, 16, 32
strt_glitch  input  1  start checker result, valid the cycle after strt_chk_en pulse
par_err  input  1  parity checker result, registered, valid the cycle after the parity-bit sample strobe
stp_err  input  1  stop checker result, valid the cycle after stp_chk_en pulse
edge_cnt  output  PRESC_W  oversample index within current bit, 0..prescale-1
bit_cnt  output  4  bit index within frame (0 = start)
dat_samp_en  output  1  sampler enable; high in all states except IDLE
strt_chk_en  output  1  one-cycle pulse in START at edge_cnt == CHK
deser_en  output  1  one-cycle pulse in DATA at edge_cnt == CHK
par_check_en  output  1  level; high throughout PARITY and STOP states when PAR_EN
stp_chk_en  output  1  one-cycle pulse in STOP at edge_cnt == CHK
data_valid  output  1  one-cycle pulse in DONE when frame error-free

Behaviour:
- Reset (rst low, async): state=IDLE. edge_cnt=0. bit_cnt=0. All enables, data_valid and internal error flags = 0.
- CHK = prescale/2 + 2. The sampler votes on edges prescale/2-1, prescale/2 and prescale/2+1; its result is stable at CHK.
- prescale is latched on the IDLE->START transition and held for the whole frame; mid-frame changes are ignored.
- edge_cnt increments every cycle outside IDLE/DONE. It wraps to 0 at latched prescale-1 ("bit end"). bit_cnt increments at each bit end.
- IDLE: RX_IN==0 -> START, with edge_cnt=0 and bit_cnt=0.
- START: at bit end, if strt_glitch==1 -> IDLE (frame dropped, no data_valid). Otherwise -> DATA.
- DATA: deser_en pulses once per bit. After the DATA_SIZE-th bit end (bit_cnt == DATA_SIZE) -> PARITY if PAR_EN, else -> STOP. PAR_EN is latched at START.
- PARITY: sample strobe at CHK. At CHK+1, par_err is captured into sticky flag perr_q. At bit end -> STOP.
- STOP: stp_chk_en pulses at CHK. At CHK+1, stp_err is captured into sticky flag serr_q. At bit end -> DONE.
- DONE (1 cycle): data_valid = ~(perr_q | serr_q). Flags clear. Next state depends on RX_IN:
  - RX_IN==0 -> START directly (back-to-back frames, edge_cnt=0).
  - RX_IN==1 -> IDLE.
- Low-to-high frame time = 1 + DATA_SIZE + PAR_EN + 1 bits of prescale cycles, plus 1 DONE cycle.
- Glitch in START: no later enable pulses in that frame. The line is re-armed in IDLE on the next cycle.
- Reset mid-frame: immediate return to IDLE. data_valid never fires for the aborted frame.
- par_check_en low outside PARITY/STOP, which holds the parity checker in reset between frames.

Test Plan:
- prescale=8, PAR_EN=1, frame 0xA5, no errors -> deser_en 8 pulses at edge 6. data_valid=1 exactly once, 8*11 cycles after start edge.
- prescale=16, PAR_EN=0, two back-to-back frames 0x3C then 0xC3 -> no IDLE cycle between frames. data_valid pulses twice, 16*10+1 cycles apart.
- prescale=8, strt_glitch=1 at START CHK+1 -> IDLE after START bit end. No deser_en, no data_valid. A new frame 4 cycles later is received correctly.
- prescale=8, PAR_EN=1, par_err=1 on parity bit -> DONE reached, data_valid stays 0. The next clean frame gives data_valid=1.
- prescale=32, PAR_EN=1, stp_err=1 -> data_valid=0. par_check_en high for exactly 64 cycles.
- rst low during DATA bit 4 -> all outputs 0 asynchronously. After release with RX_IN high, the block stays IDLE.
